// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_gen
//  Description : Converts a 1-pixel/cycle raster grey stream into 3x3 windows
//                for the Sobel gradient stage. It uses two line buffers and a
//                column shift array. Windows are emitted only for interior
//                pixels, so there are no border windows.
//                Optional feature macro: WIN_COORD_EN. When it is defined, the
//                block also outputs the window centre coordinates.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sof,
  input  logic          pix_valid,
  input  logic [7:0]    pix_in,
  output logic [23:0]   line0,
  output logic [23:0]   line1,
  output logic [23:0]   line2,
  output logic          clken,
  output logic          frame_done
`ifdef WIN_COORD_EN
  ,
  output logic [XW-1:0] win_cx,
  output logic [YW-1:0] win_cy
`endif
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;

  // Line buffers: lb1 holds row y-1, lb2 holds row y-2 (no reset, written before read)
  logic [7:0]     lb1_q [IMG_W];
  logic [7:0]     lb2_q [IMG_W];

  // Shift array columns packed {top, middle, bottom}; the left column lives in the outputs
  logic [23:0]    col_c_q;
  logic [23:0]    col_r_q;

  logic [23:0]    line0_q, line1_q, line2_q;
  logic           clken_q;
  logic           frame_done_q;

  logic           start_w;
  logic           acc_run_w;
  logic           accept_w;
  logic [XW-1:0]  ax_w;
  logic [YW-1:0]  ay_w;
  logic [7:0]     rd1_w;
  logic [7:0]     rd2_w;
  logic           x_last_w;
  logic           y_last_w;
  logic           win_ok_w;

  // Accept decode and read-before-write line-buffer access for the current pixel
  always_comb begin
    start_w   = pix_valid & sof;
    acc_run_w = pix_valid & ~sof & ((state_q == S_FILL) || (state_q == S_STREAM));
    accept_w  = start_w | acc_run_w;
    ax_w      = start_w ? '0 : x_q;
    ay_w      = start_w ? '0 : y_q;
    rd1_w     = lb1_q[ax_w];
    rd2_w     = lb2_q[ax_w];
    x_last_w  = (ax_w == X_LAST);
    y_last_w  = (ay_w == Y_LAST);
    win_ok_w  = acc_run_w && (ax_w >= XW'(2)) && (ay_w >= YW'(2));
  end

  // Line-buffer update: the older row moves down, and the new pixel enters lb1
  always_ff @(posedge clk) begin
    if (accept_w) begin
      lb2_q[ax_w] <= rd1_w;
      lb1_q[ax_w] <= pix_in;
    end
  end

  // Frame FSM, raster counters, shift array and registered window outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      col_c_q      <= '0;
      col_r_q      <= '0;
      line0_q      <= '0;
      line1_q      <= '0;
      line2_q      <= '0;
      clken_q      <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef WIN_COORD_EN
      win_cx       <= '0;
      win_cy       <= '0;
`endif
    end else begin
      clken_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (accept_w) begin
        col_c_q <= col_r_q;
        col_r_q <= {rd2_w, rd1_w, pix_in};
        if (x_last_w) begin
          x_q <= '0;
          y_q <= ay_w + YW'(1);
        end else begin
          x_q <= ax_w + XW'(1);
          y_q <= ay_w;
        end
        if (x_last_w && y_last_w) begin
          state_q      <= S_DONE;
          frame_done_q <= 1'b1;
          y_q          <= '0;
        end else if (x_last_w && (ay_w == YW'(1))) begin
          state_q <= S_STREAM;
        end else if (start_w) begin
          state_q <= S_FILL;
        end
        if (win_ok_w) begin
          clken_q <= 1'b1;
          line0_q <= {rd2_w,  col_r_q[23:16], col_c_q[23:16]};
          line1_q <= {rd1_w,  col_r_q[15:8],  col_c_q[15:8]};
          line2_q <= {pix_in, col_r_q[7:0],   col_c_q[7:0]};
`ifdef WIN_COORD_EN
          win_cx  <= ax_w - XW'(1);
          win_cy  <= ay_w - YW'(1);
`endif
        end
      end else if (state_q == S_DONE) begin
        state_q <= S_IDLE;
      end
    end
  end

  assign line0      = line0_q;
  assign line1      = line1_q;
  assign line2      = line2_q;
  assign clken      = clken_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_window_gen
//  Description : Self-checking bench for sobel_window_gen at IMG_W=IMG_H=4.
//                A frame-array reference model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int XW = 2;
  localparam int YW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sof = 1'b0;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_in = 8'h00;
  logic [23:0]   line0, line1, line2;
  logic          clken, frame_done;
`ifdef WIN_COORD_EN
  logic [XW-1:0] win_cx;
  logic [YW-1:0] win_cy;
`endif

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .line0      (line0),
    .line1      (line1),
    .line2      (line2),
    .clken      (clken),
    .frame_done (frame_done)
`ifdef WIN_COORD_EN
    ,
    .win_cx     (win_cx),
    .win_cy     (win_cy)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame image by coordinates plus the raster position
  logic [7:0]  img [H][W];
  bit          m_active = 1'b0;
  int          mx = 0;
  int          my = 0;
  logic [23:0] e_l0 = '0, e_l1 = '0, e_l2 = '0;
  int          e_cx = 0, e_cy = 0;
  int          pulses = 0;
  int          dones = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input bit e_clk, input bit e_done);
    chk("clken", {31'd0, clken}, {31'd0, e_clk});
    chk("frame_done", {31'd0, frame_done}, {31'd0, e_done});
    chk("line0", {8'd0, line0}, {8'd0, e_l0});
    chk("line1", {8'd0, line1}, {8'd0, e_l1});
    chk("line2", {8'd0, line2}, {8'd0, e_l2});
`ifdef WIN_COORD_EN
    chk("win_cx", 32'(win_cx), 32'(e_cx));
    chk("win_cy", 32'(win_cy), 32'(e_cy));
`endif
  endtask

  // One clock of stimulus, with the model's prediction checked just after the edge
  task automatic step(input bit v, input bit s, input logic [7:0] p);
    bit acc;
    bit e_clk;
    bit e_done;
    bit restart;
    e_clk   = 1'b0;
    e_done  = 1'b0;
    restart = v && s;
    if (restart) begin
      m_active = 1'b1;
      mx = 0;
      my = 0;
    end
    acc = v && m_active;
    if (acc) begin
      img[my][mx] = p;
      if (!restart && mx >= 2 && my >= 2) begin
        e_clk = 1'b1;
        e_l0 = {img[my-2][mx], img[my-2][mx-1], img[my-2][mx-2]};
        e_l1 = {img[my-1][mx], img[my-1][mx-1], img[my-1][mx-2]};
        e_l2 = {img[my][mx],   img[my][mx-1],   img[my][mx-2]};
        e_cx = mx - 1;
        e_cy = my - 1;
      end
      mx++;
      if (mx == W) begin
        mx = 0;
        my++;
        if (my == H) begin
          my = 0;
          m_active = 1'b0;
          e_done = 1'b1;
        end
      end
    end
    pix_valid = v;
    sof       = s;
    pix_in    = p;
    @(posedge clk);
    #1;
    if (clken === 1'b1) pulses++;
    if (frame_done === 1'b1) dones++;
    check_outputs(e_clk, e_done);
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    sof = 1'b0;
    rst = 1'b1;
    m_active = 1'b0;
    e_l0 = '0; e_l1 = '0; e_l2 = '0;
    e_cx = 0;  e_cy = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs(1'b0, 1'b0);
  endtask

  // Sends a full frame; mode 0 uses pixel 16*y+x, mode 1 uses random pixels
  task automatic send_frame(input int mode, input bit gaps, input int stop_x, input int stop_y);
    logic [7:0] p;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (x == stop_x && y == stop_y) return;
        if (gaps) begin
          int g;
          g = int'($urandom_range(3, 0));
          for (int k = 0; k < g; k++) step(1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
        end
        p = (mode == 0) ? 8'(16 * y + x) : 8'($urandom);
        step(1'b1, (x == 0 && y == 0), p);
      end
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    @(posedge clk);
    do_reset();

    // Pixels before any sof are dropped
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'($urandom));

    // Full frame, continuous, pattern pixels
    pulses = 0; dones = 0;
    send_frame(0, 1'b0, -1, -1);
    step(1'b0, 1'b0, 8'h00);
    chk("pulses_cont", 32'(pulses), 32'd4);
    chk("dones_cont", 32'(dones), 32'd1);
    chk("last_line0", {8'd0, line0}, 32'h131211);
    chk("last_line2", {8'd0, line2}, 32'h333231);

    // Same frame with random gaps
    pulses = 0; dones = 0;
    send_frame(0, 1'b1, -1, -1);
    chk("pulses_gaps", 32'(pulses), 32'd4);
    chk("dones_gaps", 32'(dones), 32'd1);

    // Random pixels with gaps
    for (int f = 0; f < 3; f++) send_frame(1, 1'b1, -1, -1);

    // sof reasserted at (1,2): abandon the frame and restart there
    pulses = 0; dones = 0;
    send_frame(0, 1'b0, 1, 2);
    send_frame(0, 1'b1, -1, -1);
    chk("pulses_abort", 32'(pulses), 32'd4);
    chk("dones_abort", 32'(dones), 32'd1);

    // Reset mid-frame, then pixels without sof are ignored
    send_frame(1, 1'b0, 3, 2);
    do_reset();
    pulses = 0;
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 8'($urandom));
    chk("pulses_after_rst", 32'(pulses), 32'd0);
    send_frame(1, 1'b1, -1, -1);

    // Pixels after frame end without sof
    pulses = 0; dones = 0;
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 8'($urandom));
    chk("pulses_post_frame", 32'(pulses), 32'd0);
    chk("dones_post_frame", 32'(dones), 32'd0);
    send_frame(1, 1'b0, -1, -1);
    send_frame(0, 1'b1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
